// File: rtl/nios_sd_status_ctrl.sv
// ---------------------------------------------------------------------------
// nios_sd_status_ctrl
// Avalon-MM status block for the SD card socket switches. Each raw switch
// (write-protect, card-detect) is synchronised through two flops and then
// debounced with a programmable hold time. Debounced level changes are
// latched in an edge-capture register and can raise a level interrupt.
//
// Parameters
//   DB_RESET   reset value of the debounce limit register (cycles)
//   SYNC_INIT  reset value of synchronisers and stable levels
//
// Ports
//   clk         single clock for all logic
//   reset_n     asynchronous active-low reset
//   sd_wp_n     raw write-protect switch (asynchronous)
//   sd_cd_n     raw card-detect switch (asynchronous)
//   address     register select: 0 STATUS, 1 IRQ_MASK, 2 EDGE_CAPTURE,
//               3 DB_LIMIT
//   chipselect  Avalon-MM select
//   write_n     Avalon-MM write strobe, active low
//   writedata   Avalon-MM write data
//   readdata    registered read data (1-cycle latency, always updating)
//   irq         registered level interrupt
// ---------------------------------------------------------------------------
module nios_sd_status_ctrl #(
   parameter logic [15:0] DB_RESET  = 16'd50000,
   parameter logic        SYNC_INIT = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sd_wp_n,
   input  logic        sd_cd_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   // Index 0 = write-protect, index 1 = card-detect throughout.
   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       stable_q, stable_d;
   logic [1:0][15:0] cnt_q, cnt_d;
   logic [1:0]       evt;

   logic [1:0]       mask_q, mask_d;
   logic [1:0]       edge_q, edge_d;
   logic [15:0]      db_limit_q, db_limit_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic             wr;
   logic [15:0]      lim_m1;
   logic [1:0]       clr;
   logic             unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign unused_wdata = ^writedata[31:16];

   // Limit 0 behaves as limit 1: a single differing cycle commits.
   assign lim_m1 = (db_limit_q == 16'd0) ? 16'd0 : db_limit_q - 16'd1;

   // Debouncers. The counter only advances while below limit-1, so a limit
   // lowered mid-count makes the next differing cycle commit instead of
   // letting the counter run on and wrap.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      evt      = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = 16'd0;
         end else if (cnt_q[i] < lim_m1) begin
            cnt_d[i] = cnt_q[i] + 16'd1;
         end else begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = 16'd0;
            evt[i]      = 1'b1;
         end
      end
   end

   // Register file and read mux.
   always_comb begin
      mask_d     = mask_q;
      db_limit_d = db_limit_q;
      clr        = 2'b00;
      if (wr && address == 2'd1) mask_d     = writedata[1:0];
      if (wr && address == 2'd2) clr        = writedata[1:0];
      if (wr && address == 2'd3) db_limit_d = writedata[15:0];

      // A change event in the same cycle as a write-1-clear keeps the bit set.
      edge_d = (edge_q & ~clr) | evt;

      irq_d = |(edge_q & mask_q);

      case (address)
         2'd0:    readdata_d = {29'd0, ~stable_q[1] & stable_q[0], stable_q};
         2'd1:    readdata_d = {30'd0, mask_q};
         2'd2:    readdata_d = {30'd0, edge_q};
         default: readdata_d = {16'd0, db_limit_q};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= {2{SYNC_INIT}};
         sync2_q    <= {2{SYNC_INIT}};
         stable_q   <= {2{SYNC_INIT}};
         cnt_q      <= '0;
         mask_q     <= 2'b00;
         edge_q     <= 2'b00;
         db_limit_q <= DB_RESET;
         readdata_q <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= {sd_cd_n, sd_wp_n};
         sync2_q    <= sync1_q;
         stable_q   <= stable_d;
         cnt_q      <= cnt_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         db_limit_q <= db_limit_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_nios_sd_status_ctrl.sv
module tb_nios_sd_status_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sd_wp_n, sd_cd_n;
   logic [1:0]  address;
   logic        chipselect, write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   always #5 clk = ~clk;

   nios_sd_status_ctrl #(.DB_RESET(16'd50000), .SYNC_INIT(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sd_wp_n    (sd_wp_n),
      .sd_cd_n    (sd_cd_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Reference model: switch levels as seen after the 2-flop delay, a run
   // length of consecutive cycles that the seen level disagrees with the
   // debounced level, and the register contents.
   logic        m_s1 [2];
   logic        m_s2 [2];
   logic        m_stab [2];
   int          m_run [2];
   logic [1:0]  m_mask, m_ec;
   logic [15:0] m_lim;
   logic [31:0] m_rd;
   logic        m_irq;

   logic cur_wp = 1'b1, cur_cd = 1'b1;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_stab[i] = 1'b1; m_run[i] = 0;
      end
      m_mask = 2'b00; m_ec = 2'b00; m_lim = 16'd50000; m_rd = 32'd0; m_irq = 1'b0;
   endtask

   task automatic model_step(input logic wp, input logic cd, input logic [1:0] a,
                             input logic w, input logic [31:0] wd);
      logic [31:0] nrd;
      logic        nirq;
      logic [1:0]  ev, clr;
      int          lim;
      case (a)
         2'd0:    nrd = {29'd0, (!m_stab[1] && m_stab[0]), m_stab[1], m_stab[0]};
         2'd1:    nrd = {30'd0, m_mask};
         2'd2:    nrd = {30'd0, m_ec};
         default: nrd = {16'd0, m_lim};
      endcase
      nirq = (m_ec & m_mask) != 2'b00;
      lim  = (m_lim == 16'd0) ? 1 : int'(m_lim);
      ev   = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (m_s2[i] != m_stab[i]) m_run[i] = m_run[i] + 1;
         else m_run[i] = 0;
         if (m_run[i] >= lim) begin
            m_stab[i] = ~m_stab[i];
            m_run[i]  = 0;
            ev[i]     = 1'b1;
         end
      end
      m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
      m_s1[0] = wp;      m_s1[1] = cd;
      clr  = (w && a == 2'd2) ? wd[1:0] : 2'b00;
      m_ec = (m_ec & ~clr) | ev;
      if (w && a == 2'd1) m_mask = wd[1:0];
      if (w && a == 2'd3) m_lim  = wd[15:0];
      m_rd  = nrd;
      m_irq = nirq;
   endtask

   task automatic cyc(input logic wp, input logic cd, input logic [1:0] a,
                      input logic cs, input logic wn, input logic [31:0] wd);
      sd_wp_n = wp; sd_cd_n = cd; address = a;
      chipselect = cs; write_n = wn; writedata = wd;
      @(posedge clk);
      model_step(wp, cd, a, cs & ~wn, wd);
      @(negedge clk);
      check_eq("readdata", readdata, m_rd);
      check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
   endtask

   task automatic rd(input logic [1:0] a);
      cyc(cur_wp, cur_cd, a, 1'b0, 1'b1, 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cyc(cur_wp, cur_cd, a, 1'b1, 1'b0, d);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check_eq("rst_readdata", readdata, 32'd0);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] r;
      logic [1:0]  a;
      logic        cs, wn;
      logic [15:0] lims [6];
      lims[0] = 16'd0; lims[1] = 16'd1; lims[2] = 16'd2;
      lims[3] = 16'd3; lims[4] = 16'd5; lims[5] = 16'd7;

      reset_n = 1'b1; sd_wp_n = 1'b1; sd_cd_n = 1'b1; address = 2'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
      model_reset();
      #2;
      do_reset();
      rd(3);
      check_eq("dblim_reset", readdata, 32'd50000);

      // Card inserted with limit 4, only the card-detect interrupt enabled.
      wr(3, 32'd4);
      wr(1, 32'd2);
      cur_cd = 1'b0;
      repeat (10) rd(0);
      check_eq("status_inserted", readdata, 32'h5);
      rd(2);
      check_eq("edge_cd", readdata, 32'h2);
      check_eq("irq_cd", {31'd0, irq}, 32'd1);

      // Short write-protect glitch against a limit of 8.
      wr(2, 32'd3);
      wr(3, 32'd8);
      cur_wp = 1'b0;
      repeat (5) rd(0);
      cur_wp = 1'b1;
      repeat (15) rd(0);
      check_eq("status_glitch", readdata, 32'h5);
      rd(2);
      check_eq("edge_glitch", readdata, 32'h0);
      check_eq("irq_glitch", {31'd0, irq}, 32'd0);

      // Limit 0, both events captured, then set-vs-clear collision on bit0.
      wr(3, 32'd0);
      wr(1, 32'd3);
      cur_wp = 1'b0; cur_cd = 1'b1;
      repeat (6) rd(0);
      cur_wp = 1'b1;
      rd(0);
      rd(0);
      wr(2, 32'd1);
      rd(2);
      check_eq("edge_setwins", readdata, 32'h3);
      wr(2, 32'd3);
      rd(2);
      check_eq("edge_cleared", readdata, 32'h0);
      check_eq("irq_cleared", {31'd0, irq}, 32'd0);
      rd(3);
      check_eq("dblim_zero", readdata, 32'h0);

      // Randomised traffic over a range of limits.
      for (int blk = 0; blk < 6; blk++) begin
         wr(3, {16'd0, lims[blk]});
         wr(1, $urandom_range(0, 3));
         repeat (300) begin
            if ($urandom_range(0, 4) == 0) cur_wp = ~cur_wp;
            if ($urandom_range(0, 4) == 0) cur_cd = ~cur_cd;
            a  = 2'($urandom_range(0, 3));
            cs = 1'($urandom_range(0, 1));
            wn = ($urandom_range(0, 3) != 0);
            r  = $urandom;
            if (a == 2'd3) r = r & 32'hFFFF_0007;
            cyc(cur_wp, cur_cd, a, cs, wn, r);
         end
      end

      // Reset in the middle of a long debounce.
      cur_wp = 1'b1; cur_cd = 1'b1;
      repeat (20) rd(0);
      wr(3, 32'd100);
      wr(1, 32'd3);
      cur_wp = 1'b0;
      repeat (40) rd(0);
      do_reset();
      rd(3);
      check_eq("dblim_after_rst", readdata, 32'd50000);
      wr(3, 32'd2);
      repeat (10) rd(2);
      check_eq("edge_restart", readdata, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nios_sd_status_ctrl.md
NIOS_SD_STATUS_CTRL -- requirements
Module: nios_sd_status_ctrl

Interface
REQ-001 SHALL have parameter DB_RESET, default 16'd50000: reset value of the debounce limit register (cycles).
REQ-002 SHALL have parameter SYNC_INIT, default 1'b1: reset value of synchronisers and stable levels (pulled-up, inactive).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port sd_wp_n, input, 1: raw SD write-protect switch, asynchronous.
REQ-006 SHALL have port sd_cd_n, input, 1: raw SD card-detect switch, asynchronous.
REQ-007 SHALL have port address, input, 2: Avalon-MM register select.
REQ-008 SHALL have port chipselect, input, 1: Avalon-MM select.
REQ-009 SHALL have port write_n, input, 1: Avalon-MM write strobe, active low.
REQ-010 SHALL have port writedata, input, 32: Avalon-MM write data.
REQ-011 SHALL have port readdata, output, 32: registered Avalon-MM read data.
REQ-012 SHALL have port irq, output, 1: registered level interrupt.

Function
REQ-013 SHALL synchronise each raw input through two flip-flops before any use.
REQ-014 SHALL run one independent debouncer per input, each with a 16-bit counter and stable-level register.
REQ-015 Debouncer SHALL clear its counter to 0 in any cycle where the synchronised level equals the stable level.
REQ-016 Debouncer SHALL increment its counter in any cycle where the levels differ and counter < limit-1.
REQ-017 When the levels differ and counter >= limit-1, debouncer SHALL load the stable level from the synchroniser, clear the counter and pulse a 1-cycle change event.
REQ-018 Effective limit SHALL be max(DB_LIMIT,1); the stable level therefore updates exactly limit cycles after the synchronised level changes and holds steady.
REQ-019 A glitch shorter than limit cycles SHALL produce no stable-level change and no event.
REQ-020 Register map, with write = chipselect & ~write_n; all unused bits read 0.
REQ-021 addr 0 STATUS (RO): bit0 = stable wp_n, bit1 = stable cd_n, bit2 = card_ready = ~stable_cd_n & stable_wp_n; writes ignored.
REQ-022 addr 1 IRQ_MASK (RW): bits[1:0], bit0 = wp event, bit1 = cd event.
REQ-023 addr 2 EDGE_CAPTURE (RW1C): bits[1:0] set by the matching change event; writing 1 clears a bit.
REQ-024 addr 3 DB_LIMIT (RW): bits[15:0] hold the debounce limit.
REQ-025 On simultaneous change event and write-1-clear on the same EDGE_CAPTURE bit, set SHALL win and the bit SHALL remain 1.
REQ-026 A DB_LIMIT write SHALL take effect the following cycle; a counter already >= new limit-1 SHALL complete on its next differing cycle, with no wrap-around.
REQ-027 readdata SHALL update every clock from the address mux regardless of chipselect, giving 1-cycle read latency.
REQ-028 irq SHALL be registered as |(EDGE_CAPTURE & IRQ_MASK), asserting 1 cycle after the captured bit sets and deasserting 1 cycle after clear or mask.
REQ-029 Writes SHALL complete in one cycle with no wait states.

Reset
REQ-030 On reset_n low, immediately and asynchronously: readdata = 0, irq = 0, IRQ_MASK = 0, EDGE_CAPTURE = 0, DB_LIMIT = DB_RESET, counters = 0, synchronisers and stable levels = SYNC_INIT.
REQ-031 Reset asserted mid-debounce SHALL abandon the count with no event; after release, a differing input SHALL restart counting from 0.
REQ-032 No change event SHALL be generated in the first cycles after reset solely because synchronisers initialise to SYNC_INIT.

Verification
REQ-033 DB_LIMIT=4, IRQ_MASK=2'b10, sd_cd_n 1->0 held -> STATUS bit1=0 and bit2=1 exactly 2+4 cycles after the edge; EDGE_CAPTURE=2'b10; irq=1 one cycle later.
REQ-034 DB_LIMIT=8, sd_wp_n pulsed low for 5 cycles -> STATUS unchanged, EDGE_CAPTURE=0, irq=0.
REQ-035 EDGE_CAPTURE=2'b11, write addr 2 data 1 in the same cycle a new wp event fires -> bit0 stays 1; a later write of 3 -> reads 0 and irq drops one cycle after the write.
REQ-036 Write DB_LIMIT=0, toggle sd_wp_n -> stable level updates 1 cycle after synchronised change; read addr 3 returns 0x00000000.
REQ-037 Assert reset_n mid-count with DB_LIMIT=100 and IRQ_MASK=3 -> readdata=0, irq=0 immediately; DB_LIMIT reads 50000 after release.
